// File: rtl/gpio_in_cond_if.sv
// gpio_in_cond_if
// Bundles the pad-side inputs, filter configuration and conditioned outputs of
// the GPIO input conditioner.
//   cio_gpio_i     raw pad levels, asynchronous to the conditioner clock
//   filt_en_i      per-pin glitch filter enable
//   filt_cycles_i  shared stability threshold N (0 disables filtering)
//   gpio_o         conditioned pin levels
//   rise_o/fall_o  one-cycle per-pin edge pulses on gpio_o
//   chg_o          OR of all edge pulses
// master: the side that owns the pads/config and consumes the levels.
// slave:  the conditioner itself.
interface gpio_in_cond_if #(
  parameter int NumPins  = 32,
  parameter int CntWidth = 8
);
  logic [NumPins-1:0]  cio_gpio_i;
  logic [NumPins-1:0]  filt_en_i;
  logic [CntWidth-1:0] filt_cycles_i;
  logic [NumPins-1:0]  gpio_o;
  logic [NumPins-1:0]  rise_o;
  logic [NumPins-1:0]  fall_o;
  logic                chg_o;

  modport master (
    output cio_gpio_i, filt_en_i, filt_cycles_i,
    input  gpio_o, rise_o, fall_o, chg_o
  );

  modport slave (
    input  cio_gpio_i, filt_en_i, filt_cycles_i,
    output gpio_o, rise_o, fall_o, chg_o
  );
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond
// Synchronizes asynchronous GPIO pad inputs, optionally rejects glitches shorter
// than a programmable number of cycles, and produces per-pin rise/fall pulses.
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  synchronous, active-high reset
//   bus    gpio_in_cond_if.slave (pads, filter config, conditioned outputs)
// SyncStages must be in 2..4.
module gpio_in_cond #(
  parameter int NumPins    = 32,
  parameter int SyncStages = 2,
  parameter int CntWidth   = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  gpio_in_cond_if.slave  bus
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [SyncStages-1:0][NumPins-1:0] sync_q;
  logic [NumPins-1:0]                 s;
  logic [NumPins-1:0]                 cand_q, cand_d;
  logic [NumPins-1:0][CntWidth-1:0]   cnt_q, cnt_d;
  logic [NumPins-1:0]                 gpio_q, gpio_d;
  logic [NumPins-1:0]                 rise_q, fall_q;
  logic                               chg_q;
  logic                               n_zero;

  assign s      = sync_q[SyncStages-1];
  assign n_zero = (bus.filt_cycles_i == '0);

  // The threshold compare uses the count as updated on this edge, so a level
  // that has been at s for N+1 consecutive cycles is accepted on the last of
  // them. The live compare also lets a lowered threshold take effect at once.
  // cand/cnt run in both modes so turning the filter on needs no flush.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    gpio_d = gpio_q;
    for (int i = 0; i < NumPins; i++) begin
      if (s[i] != cand_q[i]) begin
        cand_d[i] = s[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end

      if (!bus.filt_en_i[i] || n_zero) begin
        gpio_d[i] = s[i];
      end else if (cnt_d[i] >= bus.filt_cycles_i) begin
        gpio_d[i] = cand_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      gpio_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync_q[0] <= bus.cio_gpio_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      gpio_q <= gpio_d;
      // Pulses are registered alongside gpio_q so they line up with the
      // first cycle the new level is visible.
      rise_q <= gpio_d & ~gpio_q;
      fall_q <= ~gpio_d & gpio_q;
      chg_q  <= |(gpio_d ^ gpio_q);
    end
  end

  assign bus.gpio_o = gpio_q;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;
  assign bus.chg_o  = chg_q;

endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL take parameter NumPins, default 32: number of GPIO input pins conditioned.
REQ-002 SHALL take parameter SyncStages, default 2, legal 2..4: synchronizer flop depth per pin.
REQ-003 SHALL take parameter CntWidth, default 8: width of per-pin stability counter and threshold.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_i  input  1  reset: synchronous, active-high.
REQ-006 cio_gpio_i  input  NumPins  raw pad inputs, asynchronous to clk_i.
REQ-007 filt_en_i  input  NumPins  per-pin filter enable, quasi-static, sampled every cycle.
REQ-008 filt_cycles_i  input  CntWidth  stability threshold N, shared by all pins, sampled every cycle.
REQ-009 gpio_o  output  NumPins  conditioned pin levels; drives the GPIO block's data-in path.
REQ-010 rise_o  output  NumPins  one-cycle pulse per pin on a 0->1 change of gpio_o.
REQ-011 fall_o  output  NumPins  one-cycle pulse per pin on a 1->0 change of gpio_o.
REQ-012 chg_o  output  1  OR of all rise_o and fall_o bits, same cycle.

Function
REQ-013 Each pin SHALL pass through a SyncStages-deep flop chain; s[i] denotes the last stage.
REQ-014 Each pin SHALL hold a candidate bit cand[i] and a counter cnt[i] of width CntWidth.
REQ-015 Per edge: if s[i] != cand[i], then cand[i] <= s[i] and cnt[i] <= 0; otherwise cnt[i] increments, saturating at all-ones (no wrap).
REQ-016 Filtered mode (filt_en_i[i]=1 and N != 0): gpio_o[i] <= cand[i] on any edge where cnt[i] >= N.
REQ-017 Unfiltered mode (filt_en_i[i]=0 or N=0): gpio_o[i] <= s[i] every edge.
REQ-018 cand/cnt SHALL track s in both modes, so enabling the filter mid-run takes effect on the next edge with no flush.
REQ-019 Latency, pin stable after a change: gpio_o updates SyncStages+N+1 edges after the first capturing edge (filtered) and SyncStages+1 edges after it (unfiltered).
REQ-020 Glitch rule, filtered: a level held at s for >= N+1 consecutive cycles SHALL propagate; a level held for <= N cycles SHALL NOT change gpio_o.
REQ-021 Lowering filt_cycles_i mid-count SHALL be compared live (>=), so a pin already at cnt >= new N updates on the next edge; raising N SHALL delay the update accordingly.
REQ-022 rise_o[i]/fall_o[i] SHALL be registered and asserted in exactly the cycle gpio_o[i] first shows its new value, for one cycle only.
REQ-023 Pins SHALL be fully independent; simultaneous changes on multiple pins SHALL raise all corresponding pulses in the same cycle.
REQ-024 The block SHALL have no handshake; gpio_o is valid every cycle, and the consumer samples it continuously.

Reset
REQ-025 While rst_i=1 at an edge: all sync flops, cand, cnt, gpio_o, rise_o, fall_o, and chg_o SHALL be 0.
REQ-026 Reset asserted mid-count SHALL discard the pending candidate; after release, a pin already high SHALL be treated as a fresh 0->1 change and obey REQ-019 with rise_o pulsing.
REQ-027 Reset state SHALL produce no rise_o or fall_o pulse in the first edge after release.

Verification
REQ-028 Unfiltered path: filt_en_i=0, pin 5 set 0->1 -> gpio_o[5]=1 and rise_o[5]=1 for one cycle, 3 edges after capture (SyncStages=2).
REQ-029 Filter pass: filt_en_i=all ones, N=4, pin 0 high for 10 cycles -> gpio_o[0]=1 exactly 7 edges after capture; one rise_o pulse; chg_o=1 in the same cycle.
REQ-030 Glitch reject: N=4, pin 3 high pulse of 4 cycles then 5 cycles -> the first pulse produces no output change; the second pulse produces gpio_o[3] rise, then fall, each with one pulse.
REQ-031 Live threshold: N=200, pin 7 high for 50 cycles, then N set to 10 -> gpio_o[7]=1 on the next edge.
REQ-032 Multi-pin and saturation: pins 0 and 31 toggle in the same cycle with N=0 -> both pulses in the same cycle; a pin held high for 300 cycles with N=255 -> cnt saturates, gpio_o stays 1, and no extra pulses occur.
REQ-033 Reset mid-operation: rst_i pulsed while pin 2 is high and mid-count -> all outputs 0; after release, gpio_o[2]=1 per REQ-019 with a single rise_o pulse.
